// File: rtl/enq_arb_pkg.sv
// Shared defaults for the four-way enqueue arbiter in front of the 38-bit one-entry FIFO.
package enq_arb_pkg;

    localparam int WIDTH = 38;
    localparam int NPORT = 4;
    localparam int IDXW  = $clog2(NPORT);

    typedef logic [WIDTH-1:0] payload_t;

endpackage

// File: rtl/enq_rr_arbiter_if.sv
// ENA/RDY method ports of the arbiter: per-producer enq side plus the FIFO-facing enq side.
interface enq_rr_arbiter_if #(
    parameter int WIDTH = enq_arb_pkg::WIDTH,
    parameter int NPORT = enq_arb_pkg::NPORT
);

    localparam int IDXW = $clog2(NPORT);

    // in_* maps to in$enq__*, out_* maps to out$enq__* / out$grant
    logic [NPORT-1:0]       in_enq_ena;
    logic [NPORT*WIDTH-1:0] in_enq_v;
    logic [NPORT-1:0]       in_enq_rdy;
    logic                   out_enq_ena;
    logic [WIDTH-1:0]       out_enq_v;
    logic                   out_enq_rdy;
    logic [IDXW-1:0]        out_grant;

    modport master (
        output in_enq_ena, in_enq_v, out_enq_rdy,
        input  in_enq_rdy, out_enq_ena, out_enq_v, out_grant
    );

    modport slave (
        input  in_enq_ena, in_enq_v, out_enq_rdy,
        output in_enq_rdy, out_enq_ena, out_enq_v, out_grant
    );

endinterface

// File: rtl/enq_rr_arbiter_rr_select.sv
// Round-robin pick: rotate the request vector so ptr+1 sits at bit 0, take the lowest set
// bit, then rotate the index back.
module rr_select #(
    parameter  int NPORT = enq_arb_pkg::NPORT,
    localparam int IDXW  = $clog2(NPORT)
) (
    input  logic [NPORT-1:0] req,
    input  logic [IDXW-1:0]  ptr,
    output logic             any,
    output logic [IDXW-1:0]  sel
);

    logic [IDXW-1:0]  start;
    logic [IDXW-1:0]  enc;
    logic [NPORT-1:0] rot;

    // NOTE: combinational blocks use blocking '=' so later statements see earlier results.
    always_comb begin
        start = ptr + 1'b1;
        rot   = NPORT'({req, req} >> start);
        enc   = '0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (rot[i]) enc = IDXW'(i);
        end
        any = |req;
        sel = enc + start;
    end

endmodule

// File: rtl/enq_rr_arbiter.sv
// Four one-entry holding slots drained round-robin into a single FIFO enq port.
module enq_rr_arbiter #(
    parameter int WIDTH = enq_arb_pkg::WIDTH,
    parameter int NPORT = enq_arb_pkg::NPORT
) (
    input logic             CLK,
    input logic             nRST,
    enq_rr_arbiter_if.slave bus
);

    localparam int IDXW = $clog2(NPORT);

    logic [NPORT-1:0] full_q, full_d;
    logic [WIDTH-1:0] data_q [NPORT];
    logic [WIDTH-1:0] data_d [NPORT];
    logic [IDXW-1:0]  ptr_q, ptr_d;
    logic [IDXW-1:0]  grant_q, grant_d;
    logic [IDXW-1:0]  sel;
    logic             any;
    logic             push;

    rr_select #(.NPORT(NPORT)) u_rr_select (
        .req (full_q),
        .ptr (ptr_q),
        .any (any),
        .sel (sel)
    );

    // Drain clears before refill sets, so a same-cycle drain+refill leaves the slot full.
    always_comb begin
        push    = any & bus.out_enq_rdy;
        full_d  = full_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        if (push) begin
            full_d[sel] = 1'b0;
            ptr_d       = sel;
            grant_d     = sel;
        end
        for (int i = 0; i < NPORT; i++) begin
            if (bus.in_enq_ena[i]) begin
                full_d[i] = 1'b1;
                data_d[i] = bus.in_enq_v[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        bus.in_enq_rdy = '0;
        for (int i = 0; i < NPORT; i++) begin
            bus.in_enq_rdy[i] = !full_q[i] | (push & (sel == IDXW'(i)));
        end
    end

    assign bus.out_enq_ena = push;
    assign bus.out_enq_v   = data_q[sel];
    assign bus.out_grant   = grant_d;

    // ptr resets to the last port so port 0 is searched first.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            full_q  <= '0;
            ptr_q   <= IDXW'(NPORT - 1);
            grant_q <= '0;
        end else begin
            full_q  <= full_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    // NOTE: payload storage is deliberately not reset; full_q alone says which slots are valid.
    always_ff @(posedge CLK) begin
        data_q <= data_d;
    end

    ena_without_rdy : assert property (@(posedge CLK) disable iff (!nRST)
        (bus.in_enq_ena & ~bus.in_enq_rdy) == '0);

endmodule

// File: tb/tb_enq_rr_arbiter.sv
// Directed bench for enq_rr_arbiter: reset, single port, rotation, back-pressure,
// drain/refill, pointer wrap and mid-run reset.
module tb_enq_rr_arbiter;

    import enq_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    enq_rr_arbiter_if #(.WIDTH(WIDTH), .NPORT(NPORT)) bus ();

    enq_rr_arbiter #(.WIDTH(WIDTH), .NPORT(NPORT)) dut (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_v(input int port, input payload_t val);
        bus.in_enq_v[port*WIDTH +: WIDTH] = val;
    endtask

    // Apply one cycle of inputs, check outputs at the falling edge, then advance past the rising edge.
    task automatic cyc(input string tag, input logic [3:0] ena, input logic fifo_rdy,
                       input logic e_ena, input payload_t e_v, input logic chk_v,
                       input logic [1:0] e_grant, input logic [3:0] e_rdy);
        bus.in_enq_ena  = ena;
        bus.out_enq_rdy = fifo_rdy;
        @(negedge clk);
        check({tag, ".ena"},   64'(bus.out_enq_ena), 64'(e_ena));
        check({tag, ".grant"}, 64'(bus.out_grant),   64'(e_grant));
        check({tag, ".rdy"},   64'(bus.in_enq_rdy),  64'(e_rdy));
        if (chk_v) check({tag, ".v"}, 64'(bus.out_enq_v), 64'(e_v));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        bus.in_enq_ena  = '0;
        bus.in_enq_v    = '0;
        bus.out_enq_rdy = 1'b1;

        #12;
        check("rst.ena",   64'(bus.out_enq_ena), 64'h0);
        check("rst.grant", 64'(bus.out_grant),   64'h0);
        check("rst.rdy",   64'(bus.in_enq_rdy),  64'hf);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All four slots filled at once rotate out 0,1,2,3.
        for (int i = 0; i < 4; i++) set_v(i, payload_t'(38'hA0 + i));
        cyc("rr_fill", 4'b1111, 1'b1, 1'b0, '0,     1'b0, 2'd0, 4'b1111);
        cyc("rr0",     4'b0000, 1'b1, 1'b1, 38'hA0, 1'b1, 2'd0, 4'b0001);
        cyc("rr1",     4'b0000, 1'b1, 1'b1, 38'hA1, 1'b1, 2'd1, 4'b0011);
        cyc("rr2",     4'b0000, 1'b1, 1'b1, 38'hA2, 1'b1, 2'd2, 4'b0111);
        cyc("rr3",     4'b0000, 1'b1, 1'b1, 38'hA3, 1'b1, 2'd3, 4'b1111);
        cyc("rr_idle", 4'b0000, 1'b1, 1'b0, '0,     1'b0, 2'd3, 4'b1111);

        set_v(2, 38'h15);
        cyc("s_fill",  4'b0100, 1'b1, 1'b0, '0,     1'b0, 2'd3, 4'b1111);
        cyc("s_push",  4'b0000, 1'b1, 1'b1, 38'h15, 1'b1, 2'd2, 4'b1111);
        cyc("s_idle",  4'b0000, 1'b1, 1'b0, '0,     1'b0, 2'd2, 4'b1111);

        // Back-pressure with ptr=2: slot 0 is next in line, slot 2 waits behind it.
        set_v(0, 38'h40);
        set_v(2, 38'h42);
        cyc("bp_fill", 4'b0101, 1'b0, 1'b0, '0, 1'b0, 2'd2, 4'b1111);
        for (int k = 0; k < 5; k++) begin
            cyc($sformatf("bp_hold%0d", k), 4'b0000, 1'b0, 1'b0, 38'h40, 1'b1, 2'd2, 4'b1010);
        end
        cyc("bp_rel0", 4'b0000, 1'b1, 1'b1, 38'h40, 1'b1, 2'd0, 4'b1011);
        cyc("bp_rel2", 4'b0000, 1'b1, 1'b1, 38'h42, 1'b1, 2'd2, 4'b1111);
        cyc("bp_idle", 4'b0000, 1'b1, 1'b0, '0,     1'b0, 2'd2, 4'b1111);

        // ptr=2 with ports 0 and 3 pending: search order 3,0,1,2.
        set_v(0, 38'h30);
        set_v(3, 38'h33);
        cyc("fw_fill", 4'b1001, 1'b1, 1'b0, '0,     1'b0, 2'd2, 4'b1111);
        cyc("fw3",     4'b0000, 1'b1, 1'b1, 38'h33, 1'b1, 2'd3, 4'b1110);
        cyc("fw0",     4'b0000, 1'b1, 1'b1, 38'h30, 1'b1, 2'd0, 4'b1111);
        cyc("fw_idle", 4'b0000, 1'b1, 1'b0, '0,     1'b0, 2'd0, 4'b1111);

        set_v(1, 38'h11);
        cyc("dr_fill",  4'b0010, 1'b1, 1'b0, '0,     1'b0, 2'd0, 4'b1111);
        set_v(1, 38'h22);
        cyc("dr_drain", 4'b0010, 1'b1, 1'b1, 38'h11, 1'b1, 2'd1, 4'b1111);
        cyc("dr_next",  4'b0000, 1'b1, 1'b1, 38'h22, 1'b1, 2'd1, 4'b1111);
        cyc("dr_idle",  4'b0000, 1'b1, 1'b0, '0,     1'b0, 2'd1, 4'b1111);

        // Mid-run reset with slots 1 and 3 full and the FIFO about to accept.
        set_v(1, 38'h61);
        set_v(3, 38'h63);
        cyc("mr_fill", 4'b1010, 1'b0, 1'b0, '0, 1'b0, 2'd1, 4'b1111);
        bus.in_enq_ena  = '0;
        bus.out_enq_rdy = 1'b1;
        #1;
        check("mr_pre.ena", 64'(bus.out_enq_ena), 64'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_async.ena",   64'(bus.out_enq_ena), 64'h0);
        check("mr_async.rdy",   64'(bus.in_enq_rdy),  64'hf);
        check("mr_async.grant", 64'(bus.out_grant),   64'h0);
        @(posedge clk);
        #1;
        check("mr_hold.ena", 64'(bus.out_enq_ena), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("mr_idle", 4'b0000, 1'b1, 1'b0, '0, 1'b0, 2'd0, 4'b1111);

        // After reset port 0 must win over port 2 (ptr back at 3).
        set_v(0, 38'h70);
        set_v(2, 38'h72);
        cyc("pr_fill", 4'b0101, 1'b1, 1'b0, '0,     1'b0, 2'd0, 4'b1111);
        cyc("pr0",     4'b0000, 1'b1, 1'b1, 38'h70, 1'b1, 2'd0, 4'b1011);
        cyc("pr2",     4'b0000, 1'b1, 1'b1, 38'h72, 1'b1, 2'd2, 4'b1111);
        cyc("pr_idle", 4'b0000, 1'b1, 1'b0, '0,     1'b0, 2'd2, 4'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
